// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the instruction memory. A host or boot interface
// streams bytes over a valid/ready handshake. Every four bytes are packed
// into one big-endian 32-bit instruction word. The packed word is written
// to the instruction memory with a one-cycle strobe. Writes go to
// consecutive word addresses starting at 0.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a CHECK state.
// CHECK runs after the last word has been written. It accepts one extra
// byte and compares that byte against the XOR of all payload bytes. If the
// two differ, error is raised.
//
// Parameters:
//   DEPTH      number of instruction words in the target memory
//   LEN_W      width of load_len; must hold values 0..DEPTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      pulse; begins a load of load_len words (ignored while busy)
//   load_len   number of words to load, sampled when start is accepted
//   byte_in    stream byte
//   byte_valid byte_in valid
//   byte_ready loader can accept a byte
//   mem_we     one-cycle write strobe per word
//   mem_addr   word address (index into memory array, not byte address)
//   mem_wdata  assembled instruction word
//   busy       load in progress
//   done       one-cycle pulse at end of load
//   error      sticky error flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int DEPTH = 1024,
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] load_len,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             error
);

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       byteCnt_q, byteCnt_d;
   logic [23:0]      shift_q, shift_d;
   logic [LEN_W-1:0] wordCnt_q, wordCnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [31:0]      memAddr_q, memAddr_d;
   logic [31:0]      memWdata_q, memWdata_d;
   logic             error_q, error_d;
   logic [LEN_W-1:0] wordCntInc;
   logic             byteAccept;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       xor_q, xor_d;
`endif

   assign wordCntInc = wordCnt_q + LEN_W'(1);
   assign byteAccept = byte_valid && byte_ready;

   assign mem_addr   = memAddr_q;
   assign mem_wdata  = memWdata_q;
   assign error      = error_q;

   // State and datapath registers. Reset clears any partially assembled
   // word. Reset does not affect words already written to memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         byteCnt_q  <= '0;
         shift_q    <= '0;
         wordCnt_q  <= '0;
         len_q      <= '0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byteCnt_q  <= byteCnt_d;
         shift_q    <= shift_d;
         wordCnt_q  <= wordCnt_d;
         len_q      <= len_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   // Next-state and output decode. The first three bytes of a word are
   // held in shift_q. mem_wdata is only updated on the 4th byte, so it
   // keeps its previous value until the next WRITE cycle.
   always_comb begin
      state_d    = state_q;
      byteCnt_d  = byteCnt_q;
      shift_d    = shift_q;
      wordCnt_d  = wordCnt_q;
      len_d      = len_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d      = xor_q;
`endif
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d     = load_len;
               error_d   = 1'b0;
               memAddr_d = '0;
               wordCnt_d = '0;
               byteCnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d     = '0;
`endif
               if (load_len == '0) begin
                  state_d = DONE;
               end else if (32'(load_len) > 32'(DEPTH)) begin
                  error_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RECV;
               end
            end
         end

         RECV: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byteAccept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d = xor_q ^ byte_in;
`endif
               byteCnt_d = byteCnt_q + 2'd1;
               if (byteCnt_q == 2'd3) begin
                  memWdata_d = {shift_q, byte_in};
                  state_d    = WRITE;
               end else begin
                  shift_d = {shift_q[15:0], byte_in};
               end
            end
         end

         WRITE: begin
            mem_we    = 1'b1;
            busy      = 1'b1;
            memAddr_d = memAddr_q + 32'd1;
            wordCnt_d = wordCntInc;
            if (wordCntInc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = RECV;
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         // Trailing checksum byte: it must equal the XOR of every
         // payload byte in this load.
         CHECK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byteAccept) begin
               if (byte_in != xor_q) begin
                  error_d = 1'b1;
               end
               state_d = DONE;
            end
         end
`endif

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader.
//
// The driver builds each byte stream and works out, at word level, the
// writes the loader must produce. Each expected write is a big-endian word
// and its index. These expectations are queued. It also records the error
// flag and final mem_addr expected when done pulses.
//
// A monitor runs on every falling edge. It compares each mem_we cycle
// against the queue, and compares each done pulse against the recorded
// expectations. Build with +define+IMEM_LOADER_CHECKSUM_EN to add the
// trailing checksum byte.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int DEPTH = 1024;
   localparam int LEN_W = 11;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [LEN_W-1:0] load_len;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             busy;
   logic             done;
   logic             error;

   int checkCount = 0;
   int failCount  = 0;
   int doneCount  = 0;

   logic [7:0]  byteQ[$];
   logic [31:0] expAddrQ[$];
   logic [31:0] expDataQ[$];
   logic [31:0] logAddr[$];
   logic [31:0] logData[$];
   logic        expErr;
   logic [31:0] expFinalAddr;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   imem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load_len   (load_len),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point. Every check in the bench goes through here,
   // so the counts in the summary line cover all of them.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Append n random payload bytes to the stream.
   task automatic fillRandom(input int n);
      for (int i = 0; i < n; i++) byteQ.push_back(8'($urandom_range(0, 255)));
   endtask

   // Monitor: every write must match the next expected (index, word) pair.
   // Every done pulse must leave busy low and show the expected error flag
   // and final address.
   always @(negedge clk) begin
      logic [31:0] a;
      logic [31:0] d;
      if (rst_n) begin
         if (mem_we) begin
            checkOutput("write_ready_low", {31'b0, byte_ready}, 32'd0);
            checkOutput("write_busy", {31'b0, busy}, 32'd1);
            if (expAddrQ.size() == 0) begin
               checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
               a = expAddrQ.pop_front();
               d = expDataQ.pop_front();
               checkOutput("write_addr", mem_addr, a);
               checkOutput("write_data", mem_wdata, d);
            end
            logAddr.push_back(mem_addr);
            logData.push_back(mem_wdata);
         end
         if (done) begin
            doneCount++;
            checkOutput("done_busy", {31'b0, busy}, 32'd0);
            checkOutput("done_error", {31'b0, error}, {31'b0, expErr});
            checkOutput("done_addr", mem_addr, expFinalAddr);
         end
      end
   end

   // Run one complete load using the bytes already in byteQ. gaps toggles
   // byte_valid at random. injStart raises start part way through, and the
   // loader must ignore it. ckFlip corrupts the checksum byte.
   task automatic applyStimulus(input int len, input bit gaps, input bit injStart, input logic [7:0] ckFlip);
      int nPay;
      int nBytes;
      int idx;
      int cyc;
      int doneBefore;
      logic [7:0] ck;
      bit normal;

      normal = (len > 0) && (len <= DEPTH);
      nPay   = normal ? len * 4 : 0;
      nBytes = nPay + ((normal && CK_EN) ? 1 : 0);
      ck     = 8'h00;
      for (int i = 0; i < nPay; i++) ck ^= byteQ[i];
      ck ^= ckFlip;

      // Word-level reference: word k is bytes 4k..4k+3, big-endian.
      for (int k = 0; k < nPay / 4; k++) begin
         expAddrQ.push_back(32'(k));
         expDataQ.push_back({byteQ[4*k], byteQ[4*k+1], byteQ[4*k+2], byteQ[4*k+3]});
      end
      expErr       = (len > DEPTH) || (normal && CK_EN && (ckFlip != 8'h00));
      expFinalAddr = normal ? 32'(len) : 32'd0;
      logAddr.delete();
      logData.delete();
      doneBefore = doneCount;

      @(negedge clk);
      start    = 1'b1;
      load_len = LEN_W'(len);
      @(negedge clk);
      start = 1'b0;
      if (!normal) begin
         checkOutput("done_latency", {31'b0, done}, 32'd1);
      end else begin
         checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
      end

      idx = 0;
      cyc = 0;
      while (idx < nBytes && cyc < nBytes * 8 + 100) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         start      = (injStart && idx == 2) ? 1'b1 : 1'b0;
         load_len   = injStart ? LEN_W'(1) : LEN_W'(len);
         byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_in    = (idx < nPay) ? byteQ[idx] : ck;
         if (byte_valid && byte_ready) idx++;
      end
      if (idx < nBytes) checkOutput("feed_timeout", 32'(idx), 32'(nBytes));
      @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b0;

      cyc = 0;
      while (doneCount == doneBefore && cyc < 50) begin
         @(posedge clk);
         cyc++;
      end
      checkOutput("done_seen", 32'(doneCount - doneBefore), 32'd1);
      @(negedge clk);
      checkOutput("writes_left", 32'(expAddrQ.size()), 32'd0);
      expAddrQ.delete();
      expDataQ.delete();
      byteQ.delete();
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      start      = 1'b0;
      load_len   = '0;
      byte_in    = '0;
      byte_valid = 1'b0;
      expErr       = 1'b0;
      expFinalAddr = 32'd0;
      #12;
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_ready", {31'b0, byte_ready}, 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
      checkOutput("rst_error", {31'b0, error}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Start a load, accept two bytes, then reset mid-word.
      @(negedge clk);
      start    = 1'b1;
      load_len = LEN_W'(1);
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b1;
      byte_in    = 8'hDE;
      @(negedge clk);
      byte_in = 8'hAD;
      @(negedge clk);
      byte_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("midrst_we", {31'b0, mem_we}, 32'd0);
      checkOutput("midrst_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      byteQ = '{8'h8C, 8'h01, 8'h00, 8'h04};
      applyStimulus(1, 1'b0, 1'b0, 8'h00);
      checkOutput("rst_load_count", 32'(logData.size()), 32'd1);
      if (logData.size() > 0) checkOutput("rst_load_word", logData[0], 32'h8C010004);

      // Two words streamed back to back.
      byteQ = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
      applyStimulus(2, 1'b0, 1'b0, 8'h00);
      checkOutput("tw_count", 32'(logData.size()), 32'd2);
      if (logData.size() == 2) begin
         checkOutput("tw_word0", logData[0], 32'h20080005);
         checkOutput("tw_word1", logData[1], 32'h01095020);
         checkOutput("tw_addr1", logAddr[1], 32'd1);
      end

      // Gappy stream, then start asserted while busy.
      fillRandom(12);
      applyStimulus(3, 1'b1, 1'b0, 8'h00);
      fillRandom(16);
      applyStimulus(4, 1'b1, 1'b1, 8'h00);

      // Boundaries: empty load and oversize load.
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      checkOutput("len0_error", {31'b0, error}, 32'd0);
      applyStimulus(DEPTH + 1, 1'b0, 1'b0, 8'h00);
      checkOutput("over_error", {31'b0, error}, 32'd1);

      // Random short loads; the next start clears the error flag.
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 6);
         fillRandom(n * 4);
         applyStimulus(n, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
      end
      checkOutput("error_cleared", {31'b0, error}, 32'd0);

      // Full-depth load.
      fillRandom(DEPTH * 4);
      applyStimulus(DEPTH, 1'b1, 1'b0, 8'h00);
      if (logAddr.size() > 0) checkOutput("full_last_addr", logAddr[logAddr.size()-1], 32'(DEPTH - 1));
      checkOutput("full_final_addr", mem_addr, 32'(DEPTH));
      checkOutput("full_error", {31'b0, error}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      byteQ = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
      applyStimulus(1, 1'b0, 1'b0, 8'h00);
      checkOutput("ck_good_error", {31'b0, error}, 32'd0);
      byteQ = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
      applyStimulus(1, 1'b0, 1'b0, 8'h01);
      checkOutput("ck_bad_error", {31'b0, error}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
